game_flow_controller: RTL and testbench

//  Top-level game sequencer for Space Invaders. Owns lives, level number and game

---
 rtl/game_flow_controller.sv | 193 +++++++++++++++++++
 tb/tb_game_flow_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_controller.sv
// ---------------------------------------------------------------------------
// game_flow_controller
//   Top-level game sequencer for Space Invaders. It owns the game phase, the
//   remaining lives and the current level, and it reacts to events from the
//   collision logic. It drives these outputs:
//     - freeze and invulnerability controls for the object movers,
//     - a level-reset pulse that reloads the alien matrix,
//     - the phase code, which the drawing mux uses to pick banners.
//
// Ports
//   clk                 system clock
//   resetN              asynchronous active-low reset
//   startOfFrame        one-clk pulse per VGA frame; timebase for all timers
//   startKey            start/restart key (level); only its rising edge acts
//   playerHit           player hit (level); a rising edge counts as one hit
//   aliensReachedBorder aliens reached the player row (level)
//   allAliensDead       alien matrix is empty (level)
//   godMode             hits never cost lives (level)
//   gameState[2:0]      0 IDLE,1 INTRO,2 PLAYING,3 HIT_RECOVER,4 CLEAR,5 OVER,6 WIN
//   lives[1:0]          remaining lives
//   level[3:0]          current level, 1..MAX_LEVEL
//   freezeObjects       movers/shooters hold position
//   playerInvulnerable  high while recovering from a hit
//   levelResetPulse     one-clk pulse on the first clk of INTRO
// ---------------------------------------------------------------------------
module game_flow_controller #(
    parameter int START_LIVES   = 3,
    parameter int INVULN_FRAMES = 90,
    parameter int BANNER_FRAMES = 120,
    parameter int MAX_LEVEL     = 5
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       startKey,
    input  logic       playerHit,
    input  logic       aliensReachedBorder,
    input  logic       allAliensDead,
    input  logic       godMode,
    output logic [2:0] gameState,
    output logic [1:0] lives,
    output logic [3:0] level,
    output logic       freezeObjects,
    output logic       playerInvulnerable,
    output logic       levelResetPulse
);

    localparam int MAX_FRAMES = (INVULN_FRAMES > BANNER_FRAMES) ? INVULN_FRAMES : BANNER_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        INTRO       = 3'd1,
        PLAYING     = 3'd2,
        HIT_RECOVER = 3'd3,
        CLEAR       = 3'd4,
        OVER        = 3'd5,
        WIN         = 3'd6
    } state_t;

    state_t           state, stateNext;
    logic [CNT_W-1:0] frameCnt, frameCntNext;
    logic [1:0]       livesNext;
    logic [3:0]       levelNext;
    logic             pulseNext;
    logic             startKeyD, playerHitD;
    logic             startEdge, hitEdge;
    logic             timedState;
    logic             bannerDone, invulnDone;

    assign startEdge = startKey && !startKeyD;
    assign hitEdge   = playerHit && !playerHitD;

    // The counter holds the number of SOFs seen since the state was entered.
    // A timer of N expires on the clk that samples the Nth SOF, so the test
    // is "SOF now and N-1 already counted".
    assign timedState = (state == INTRO) || (state == HIT_RECOVER) || (state == CLEAR);
    assign bannerDone = startOfFrame && (frameCnt == CNT_W'(BANNER_FRAMES - 1));
    assign invulnDone = startOfFrame && (frameCnt == CNT_W'(INVULN_FRAMES - 1));

    assign gameState = state;

    // ------------------------------------------------------------------
    // Next-state and next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        stateNext = state;
        livesNext = lives;
        levelNext = level;
        pulseNext = 1'b0;

        unique case (state)
            IDLE: begin
                if (startEdge) begin
                    stateNext = INTRO;
                    livesNext = 2'(START_LIVES);
                    levelNext = 4'd1;
                    pulseNext = 1'b1;
                end
            end

            INTRO: begin
                if (bannerDone) stateNext = PLAYING;
            end

            PLAYING: begin
                // Border beats clear beats hit when several arrive together.
                if (aliensReachedBorder) begin
                    stateNext = OVER;
                    livesNext = 2'd0;
                end else if (allAliensDead) begin
                    stateNext = CLEAR;
                end else if (hitEdge && !godMode) begin
                    if (lives <= 2'd1) begin
                        livesNext = 2'd0;
                        stateNext = OVER;
                    end else begin
                        livesNext = lives - 2'd1;
                        stateNext = HIT_RECOVER;
                    end
                end
            end

            HIT_RECOVER: begin
                // Hits are ignored here; that is the point of the window.
                if (aliensReachedBorder) begin
                    stateNext = OVER;
                    livesNext = 2'd0;
                end else if (allAliensDead) begin
                    stateNext = CLEAR;
                end else if (invulnDone) begin
                    stateNext = PLAYING;
                end
            end

            CLEAR: begin
                if (bannerDone) begin
                    if (level >= 4'(MAX_LEVEL)) begin
                        stateNext = WIN;
                    end else begin
                        levelNext = level + 4'd1;
                        pulseNext = 1'b1;
                        stateNext = INTRO;
                    end
                end
            end

            OVER, WIN: begin
                if (startEdge) stateNext = IDLE;
            end

            default: stateNext = IDLE;
        endcase
    end

    // Any state change restarts the timer, so each timed state starts from zero.
    always_comb begin
        frameCntNext = frameCnt;
        if (stateNext != state)
            frameCntNext = '0;
        else if (timedState && startOfFrame)
            frameCntNext = frameCnt + CNT_W'(1);
    end

    // ------------------------------------------------------------------
    // Registers. The control outputs are decoded from stateNext, so they
    // stay registered and still line up with the state they describe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state              <= IDLE;
            frameCnt           <= '0;
            lives              <= 2'(START_LIVES);
            level              <= 4'd1;
            levelResetPulse    <= 1'b0;
            playerInvulnerable <= 1'b0;
            freezeObjects      <= 1'b1;
            startKeyD          <= 1'b0;
            playerHitD         <= 1'b0;
        end else begin
            state              <= stateNext;
            frameCnt           <= frameCntNext;
            lives              <= livesNext;
            level              <= levelNext;
            levelResetPulse    <= pulseNext;
            playerInvulnerable <= (stateNext == HIT_RECOVER);
            freezeObjects      <= !((stateNext == PLAYING) || (stateNext == HIT_RECOVER));
            startKeyD          <= startKey;
            playerHitD         <= playerHit;
        end
    end

endmodule

// File: tb/tb_game_flow_controller.sv
module tb_game_flow_controller;

    localparam int START_LIVES   = 3;
    localparam int INVULN_FRAMES = 90;
    localparam int BANNER_FRAMES = 120;
    localparam int MAX_LEVEL     = 5;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame, startKey, playerHit;
    logic       aliensReachedBorder, allAliensDead, godMode;
    logic [2:0] gameState;
    logic [1:0] lives;
    logic [3:0] level;
    logic       freezeObjects, playerInvulnerable, levelResetPulse;

    int nChk  = 0;
    int nPass = 0;

    always #5 clk = ~clk;

    game_flow_controller #(
        .START_LIVES  (START_LIVES),
        .INVULN_FRAMES(INVULN_FRAMES),
        .BANNER_FRAMES(BANNER_FRAMES),
        .MAX_LEVEL    (MAX_LEVEL)
    ) dut (
        .clk                (clk),
        .resetN             (resetN),
        .startOfFrame       (startOfFrame),
        .startKey           (startKey),
        .playerHit          (playerHit),
        .aliensReachedBorder(aliensReachedBorder),
        .allAliensDead      (allAliensDead),
        .godMode            (godMode),
        .gameState          (gameState),
        .lives              (lives),
        .level              (level),
        .freezeObjects      (freezeObjects),
        .playerInvulnerable (playerInvulnerable),
        .levelResetPulse    (levelResetPulse)
    );

    // Reference model: phase code, lives, level, and frames still to wait.
    // It stores a countdown of remaining frames, not an up-counter.
    typedef struct {
        int st;
        int lv;
        int lvl;
        int remain;
        bit pulse;
        bit pk;
        bit ph;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdlReset();
        mdl_t r;
        r.st = 0; r.lv = START_LIVES; r.lvl = 1; r.remain = 0;
        r.pulse = 0; r.pk = 0; r.ph = 0;
        return r;
    endfunction

    function automatic mdl_t step(mdl_t c, bit sof, bit key, bit hit, bit border, bit dead, bit god);
        mdl_t n = c;
        bit keyE = key && !c.pk;
        bit hitE = hit && !c.ph;
        n.pk = key; n.ph = hit; n.pulse = 0;
        case (c.st)
            0: if (keyE) begin n.st = 1; n.remain = BANNER_FRAMES; n.lv = START_LIVES; n.lvl = 1; n.pulse = 1; end
            1: if (sof) begin
                   if (c.remain == 1) n.st = 2; else n.remain = c.remain - 1;
               end
            2: if (border) begin n.st = 5; n.lv = 0; end
               else if (dead) begin n.st = 4; n.remain = BANNER_FRAMES; end
               else if (hitE && !god) begin
                   if (c.lv == 1) begin n.lv = 0; n.st = 5; end
                   else begin n.lv = c.lv - 1; n.st = 3; n.remain = INVULN_FRAMES; end
               end
            3: if (border) begin n.st = 5; n.lv = 0; end
               else if (dead) begin n.st = 4; n.remain = BANNER_FRAMES; end
               else if (sof) begin
                   if (c.remain == 1) n.st = 2; else n.remain = c.remain - 1;
               end
            4: if (sof) begin
                   if (c.remain == 1) begin
                       if (c.lvl == MAX_LEVEL) n.st = 6;
                       else begin n.lvl = c.lvl + 1; n.pulse = 1; n.st = 1; n.remain = BANNER_FRAMES; end
                   end else n.remain = c.remain - 1;
               end
            default: if (keyE) n.st = 0;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) m <= mdlReset();
        else m <= step(m, startOfFrame, startKey, playerHit, aliensReachedBorder, allAliensDead, godMode);
    end

    task automatic chk(input string name, input int act, input int exp);
        nChk++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cmpModel();
        chk("model.state", int'(gameState), m.st);
        chk("model.lives", int'(lives), m.lv);
        chk("model.level", int'(level), m.lvl);
        chk("model.freeze", int'(freezeObjects), (m.st == 2 || m.st == 3) ? 0 : 1);
        chk("model.invuln", int'(playerInvulnerable), (m.st == 3) ? 1 : 0);
        chk("model.pulse", int'(levelResetPulse), int'(m.pulse));
    endtask

    // One clock; outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
        cmpModel();
    endtask

    task automatic cycs(input int n);
        repeat (n) cyc();
    endtask

    // n frames, each one SOF clk followed by three quiet clks.
    task automatic sofs(input int n);
        repeat (n) begin
            startOfFrame = 1'b1; cyc();
            startOfFrame = 1'b0; cycs(3);
        end
    endtask

    task automatic pressStart();
        startKey = 1'b1; cyc();
        startKey = 1'b0; cyc();
    endtask

    task automatic hitOnce();
        playerHit = 1'b1; cyc();
        playerHit = 1'b0; cyc();
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 0; startKey = 0; playerHit = 0;
        aliensReachedBorder = 0; allAliensDead = 0; godMode = 0;
        cycs(3);
        chk("reset.state", gameState, 0);
        chk("reset.lives", lives, 3);
        chk("reset.level", level, 1);
        chk("reset.freeze", freezeObjects, 1);
        chk("reset.pulse", levelResetPulse, 0);
        resetN = 1'b1; cyc();

        // Start: pulse on the first INTRO clk only, then the 120-frame banner.
        startKey = 1'b1; cyc();
        chk("start.state", gameState, 1);
        chk("start.pulse", levelResetPulse, 1);
        chk("start.lives", lives, 3);
        startKey = 1'b0; cyc();
        chk("start.pulse_off", levelResetPulse, 0);
        sofs(119);
        chk("intro.119", gameState, 1);
        sofs(1);
        chk("intro.120", gameState, 2);
        chk("intro.freeze", freezeObjects, 0);

        // Held hit counts once; a second edge inside the window is ignored.
        playerHit = 1'b1; cycs(5); playerHit = 1'b0; cyc();
        chk("hit.lives", lives, 2);
        chk("hit.state", gameState, 3);
        chk("hit.invuln", playerInvulnerable, 1);
        sofs(39);
        playerHit = 1'b1; sofs(1); playerHit = 1'b0;
        chk("hit.second_ignored", lives, 2);
        sofs(49);
        chk("recover.89", gameState, 3);
        sofs(1);
        chk("recover.90", gameState, 2);
        chk("recover.invuln_off", playerInvulnerable, 0);

        // Down to one life, then godMode hit and a fatal hit.
        hitOnce();
        chk("hit2.lives", lives, 1);
        sofs(INVULN_FRAMES);
        godMode = 1'b1; hitOnce(); godMode = 1'b0;
        chk("god.state", gameState, 2);
        chk("god.lives", lives, 1);
        hitOnce();
        chk("fatal.state", gameState, 5);
        chk("fatal.lives", lives, 0);

        // Restart, then clear and hit in the same clk: clear wins.
        pressStart();
        chk("over.idle", gameState, 0);
        pressStart();
        sofs(BANNER_FRAMES);
        allAliensDead = 1'b1; playerHit = 1'b1; cyc();
        allAliensDead = 1'b0; playerHit = 1'b0;
        chk("clear.state", gameState, 4);
        chk("clear.lives", lives, 3);
        sofs(BANNER_FRAMES);
        chk("clear.level", level, 2);
        chk("clear.intro", gameState, 1);
        sofs(BANNER_FRAMES);

        // Advance to the last level, then win with the key held across entry.
        for (int i = 0; i < 3; i++) begin
            allAliensDead = 1'b1; cyc(); allAliensDead = 1'b0;
            sofs(2 * BANNER_FRAMES);
        end
        chk("lvl5.level", level, 5);
        chk("lvl5.state", gameState, 2);
        allAliensDead = 1'b1; cyc(); allAliensDead = 1'b0;
        sofs(BANNER_FRAMES - 1);
        startKey = 1'b1; sofs(1);
        chk("win.state", gameState, 6);
        chk("win.level", level, 5);
        cycs(2);
        chk("win.held_key", gameState, 6);
        startKey = 1'b0; cyc();
        startKey = 1'b1; cyc();
        chk("win.restart", gameState, 0);
        startKey = 1'b0; cyc();

        // Border during hit recovery ends the game.
        pressStart();
        sofs(BANNER_FRAMES);
        hitOnce();
        sofs(10);
        aliensReachedBorder = 1'b1; cyc(); aliensReachedBorder = 1'b0;
        chk("border.state", gameState, 5);
        chk("border.lives", lives, 0);

        // Asynchronous reset in the middle of INTRO.
        pressStart();
        pressStart();
        sofs(30);
        resetN = 1'b0;
        #1;
        chk("areset.state", gameState, 0);
        chk("areset.lives", lives, 3);
        chk("areset.pulse", levelResetPulse, 0);
        cyc();
        resetN = 1'b1; cycs(2);
        chk("areset.after", gameState, 0);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
